// File: rtl/clk_rate_stepper_pkg.sv
// Shared types and constant helpers for the clock rate stepper.
// Half-period counts are computed at elaboration only; no runtime division.
package clk_rate_stepper_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2,
        ST_STEP  = 2'd3
    } pause_state_e;

    // Cycles per half-period minus one at level k, floored and clamped to at least 1.
    function automatic logic [31:0] half_count(input longint clk_hz, input longint base_hz,
                                               input int step_log2, input int k);
        longint denom;
        longint q;
        denom = (64'd2 * base_hz) << (k * step_log2);
        q     = clk_hz / denom;
        if (q <= 64'd2) begin
            return 32'd1;
        end
        return 32'(q - 64'd1);
    endfunction

endpackage

// File: rtl/btn_debounce_edge.sv
// Raw async button -> 2-FF sync -> debounce -> one-cycle press pulse (release gives nothing).
// Latency raw rise to pulse: DEBOUNCE_CYCLES+2 cycles; no backpressure, pulse is fire-and-forget.
module btn_debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1_q, s2_q;
    logic          state_q, state_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive samples that disagree with the accepted state.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (s2_q != state_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                state_d = s2_q;
                pulse_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= raw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/clk_rate_stepper.sv
// Button-controlled divided clock with geometric speed levels, pause (drained to clk_N=0) and single-step.
// Raw button rise to level/state update is DEBOUNCE_CYCLES+3 cycles; no backpressure.
module clk_rate_stepper
    import clk_rate_stepper_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int BASE_HZ         = 1,
    parameter int STEP_LOG2       = 1,
    parameter int NUM_LEVELS      = 8,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int INIT_LEVEL      = 0,
    localparam int LVL_W          = $clog2(NUM_LEVELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_faster,
    input  logic             btn_slower,
    input  logic             btn_pause,
    input  logic             btn_step,
    output logic             clk_N,
    output logic             tick,
    output logic [LVL_W-1:0] curr_level,
    output logic             paused
);

    logic p_fast, p_slow, p_pause, p_step;

    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fast (
        .clk(clk), .rst_n(rst_n), .raw(btn_faster), .pulse(p_fast));
    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_slow (
        .clk(clk), .rst_n(rst_n), .raw(btn_slower), .pulse(p_slow));
    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk(clk), .rst_n(rst_n), .raw(btn_pause), .pulse(p_pause));
    btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(clk), .rst_n(rst_n), .raw(btn_step), .pulse(p_step));

    logic [31:0] half_tab [NUM_LEVELS];

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_half
        assign half_tab[g] = half_count(64'(CLK_FREQ_HZ), 64'(BASE_HZ), STEP_LOG2, g);
    end

    pause_state_e     state_q, state_d;
    logic [31:0]      counter_q, counter_d;
    logic             clk_n_q, clk_n_d;
    logic             tick_q, tick_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [31:0]      half_sel;
    logic             lvl_chg;
    logic             counting;
    logic             toggle;

    assign half_sel = half_tab[level_q];
    assign counting = (state_q != ST_HALT);

    always_comb begin
        level_d = level_q;
        lvl_chg = 1'b0;
        if (p_fast && !p_slow && (level_q != LVL_W'(NUM_LEVELS - 1))) begin
            level_d = level_q + 1'b1;
            lvl_chg = 1'b1;
        end else if (p_slow && !p_fast && (level_q != '0)) begin
            level_d = level_q - 1'b1;
            lvl_chg = 1'b1;
        end
    end

    // A level change restarts the half-period and swallows a coincident toggle.
    assign toggle = counting && (counter_q == half_sel) && !lvl_chg;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        clk_n_d   = clk_n_q;

        if (counting) begin
            if (toggle) begin
                counter_d = '0;
                clk_n_d   = ~clk_n_q;
            end else begin
                counter_d = counter_q + 32'd1;
            end
        end
        if (lvl_chg) begin
            counter_d = '0;
        end

        unique case (state_q)
            ST_RUN: begin
                if (p_pause) begin
                    // Low phase or a falling edge right now: halt immediately with clk_N low.
                    if (!clk_n_q || toggle) begin
                        state_d   = ST_HALT;
                        counter_d = '0;
                        clk_n_d   = 1'b0;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (p_pause) begin
                    state_d = ST_RUN;
                end else if (toggle) begin
                    state_d   = ST_HALT;
                    counter_d = '0;
                end
            end
            ST_HALT: begin
                counter_d = '0;
                clk_n_d   = 1'b0;
                if (p_pause) begin
                    state_d = ST_RUN;
                end else if (p_step) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (p_pause) begin
                    state_d = ST_RUN;
                end else if (toggle && clk_n_q) begin
                    state_d   = ST_HALT;
                    counter_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase

        tick_d = clk_n_d & ~clk_n_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            counter_q <= '0;
            clk_n_q   <= 1'b0;
            tick_q    <= 1'b0;
            level_q   <= LVL_W'(INIT_LEVEL);
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            clk_n_q   <= clk_n_d;
            tick_q    <= tick_d;
            level_q   <= level_d;
        end
    end

    assign clk_N      = clk_n_q;
    assign tick       = tick_q;
    assign curr_level = level_q;
    assign paused     = (state_q != ST_RUN);

endmodule

// File: tb/tb_clk_rate_stepper.sv
// Directed bench for clk_rate_stepper with small parameters (HALF = 31, 15, 7, 3).
module tb_clk_rate_stepper;

    logic       clk;
    logic       rst_n;
    logic       btn_faster, btn_slower, btn_pause, btn_step;
    logic       clk_N, tick, paused;
    logic [1:0] curr_level;

    int checks = 0;
    int errors = 0;

    clk_rate_stepper #(
        .CLK_FREQ_HZ(64), .BASE_HZ(1), .STEP_LOG2(1), .NUM_LEVELS(4),
        .DEBOUNCE_CYCLES(2), .INIT_LEVEL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_faster(btn_faster), .btn_slower(btn_slower),
        .btn_pause(btn_pause), .btn_step(btn_step),
        .clk_N(clk_N), .tick(tick), .curr_level(curr_level), .paused(paused)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts negedges until tick is seen (or bound expires, leaving n == bound).
    task automatic wait_tick(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < bound);
    endtask

    int n;
    int bad;
    int ticks;
    int highs;
    int first_tick;
    logic [1:0] exp_lvl [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [1:0] prev_lvl [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

    initial begin
        rst_n = 1'b1;
        btn_faster = 1'b0; btn_slower = 1'b0; btn_pause = 1'b0; btn_step = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_clk_N", 32'(clk_N), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_level", 32'(curr_level), 0);
        chk("rst_paused", 32'(paused), 0);
        rst_n = 1'b1;

        // Level 0: rise after 32 cycles, then one tick per 64 cycles.
        wait_tick(200, n);
        chk("l0_first_tick", n, 32);
        chk("l0_clk_high", 32'(clk_N), 1);
        wait_tick(200, n);
        chk("l0_period", n, 64);

        // Bouncing faster button must not be accepted.
        for (int i = 0; i < 20; i++) begin
            btn_faster = (i % 2 == 0);
            @(negedge clk);
        end
        btn_faster = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_level", 32'(curr_level), 0);

        // Faster and slower together cancel.
        btn_faster = 1'b1; btn_slower = 1'b1;
        repeat (10) @(negedge clk);
        chk("both_level", 32'(curr_level), 0);
        btn_faster = 1'b0; btn_slower = 1'b0;
        repeat (10) @(negedge clk);

        // Four faster presses: level updates on the 5th edge after the raw rise.
        for (int p = 0; p < 4; p++) begin
            btn_faster = 1'b1;
            repeat (4) @(negedge clk);
            chk("press_before", 32'(curr_level), 32'(prev_lvl[p]));
            @(negedge clk);
            chk("press_after", 32'(curr_level), 32'(exp_lvl[p]));
            repeat (5) @(negedge clk);
            btn_faster = 1'b0;
            repeat (10) @(negedge clk);
        end
        wait_tick(100, n);
        wait_tick(100, n);
        chk("l3_period", n, 8);
        chk("l3_paused", 32'(paused), 0);

        // Pause lands 2 cycles into a high phase: drain, fall 2 cycles later, then halt.
        repeat (5) @(negedge clk);
        btn_pause = 1'b1;
        repeat (4) @(negedge clk);
        chk("pause_pre_paused", 32'(paused), 0);
        chk("pause_pre_clk", 32'(clk_N), 1);
        @(negedge clk);
        chk("drain_paused", 32'(paused), 1);
        chk("drain_clk", 32'(clk_N), 1);
        @(negedge clk);
        chk("drain_clk_hold", 32'(clk_N), 1);
        @(negedge clk);
        chk("drain_fall", 32'(clk_N), 0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 5) btn_pause = 1'b0;
            @(negedge clk);
            if (clk_N || tick || !paused) bad++;
        end
        chk("halt_quiet", bad, 0);

        // Single step at L3; a second step arriving during STEP is ignored.
        btn_step = 1'b1;
        ticks = 0; highs = 0; first_tick = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (tick) begin
                ticks++;
                if (first_tick == 0) first_tick = i;
            end
            if (clk_N) highs++;
            if (i == 3 || i == 10) btn_step = 1'b0;
            if (i == 7) btn_step = 1'b1;
        end
        chk("step_ticks", ticks, 1);
        chk("step_first_tick", first_tick, 9);
        chk("step_high_cycles", highs, 4);
        chk("step_back_halt_clk", 32'(clk_N), 0);
        chk("step_back_halt_paused", 32'(paused), 1);

        // Slower while halted, then reset in the middle of a step at level 2.
        btn_slower = 1'b1;
        repeat (3) @(negedge clk);
        btn_slower = 1'b0;
        repeat (2) @(negedge clk);
        chk("halt_slower_level", 32'(curr_level), 2);
        repeat (10) @(negedge clk);
        btn_step = 1'b1;
        repeat (3) @(negedge clk);
        btn_step = 1'b0;
        wait_tick(100, n);
        chk("l2_step_rise", n, 10);
        chk("l2_step_paused", 32'(paused), 1);
        rst_n = 1'b0;
        #1;
        chk("midstep_rst_clk", 32'(clk_N), 0);
        chk("midstep_rst_tick", 32'(tick), 0);
        chk("midstep_rst_paused", 32'(paused), 0);
        chk("midstep_rst_level", 32'(curr_level), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(200, n);
        chk("post_rst_first_tick", n, 32);
        chk("post_rst_paused", 32'(paused), 0);
        chk("post_rst_level", 32'(curr_level), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
